// File: rtl/tx_shift_sequencer.sv
// tx_shift_sequencer: drives one USB full-speed packet onto the D+/D- pins.
// It sends SYNC, then pulls bytes from the TX buffer into an external
// parallel-in/serial-out shift register and NRZI-encodes the serial bit
// stream with bit stuffing. It closes the packet with EOP (SE0, SE0, J).
// The line level for a bit period is a function of the level latched at
// the end of the previous period and the current period's bit. serial_in
// only changes on bit_tick edges, so the pins are stable for a whole period.
module tx_shift_sequencer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int CNT_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [CNT_W-1:0] tx_byte_count,
    input  logic             buffer_empty,
    input  logic             serial_in,
    output logic             load_data,
    output logic             byte_pop,
    output logic             shift_en,
    output logic             dp_out,
    output logic             dm_out,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_error
);

    localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CLK_W-1:0] LAST_CLK = CLK_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t           state_q, state_d;
    logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] bytes_left_q, bytes_left_d;
    logic [2:0]       ones_q, ones_d;
    logic             stuff_to_eop_q, stuff_to_eop_d;
    logic             level_q, level_d;       // 1 = J, 0 = K
    logic             tx_error_q, tx_error_d;
    logic             tx_done_q, tx_done_d;

    logic             bit_tick;
    logic             cur_bit;
    logic             nrzi_level;
    logic [2:0]       ones_next;
    logic             data_to_eop;

    assign bit_tick  = (state_q != ST_IDLE) && (clk_cnt_q == LAST_CLK);
    assign ones_next = serial_in ? (ones_q + 3'd1) : 3'd0;
    assign tx_busy   = (state_q != ST_IDLE);
    assign tx_done   = tx_done_q;
    assign tx_error  = tx_error_q;
    assign byte_pop  = load_data;

    // State and counter registers; reset lands in IDLE driving J.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            clk_cnt_q      <= '0;
            bit_idx_q      <= '0;
            bytes_left_q   <= '0;
            ones_q         <= '0;
            stuff_to_eop_q <= 1'b0;
            level_q        <= 1'b1;
            tx_error_q     <= 1'b0;
            tx_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_cnt_q      <= clk_cnt_d;
            bit_idx_q      <= bit_idx_d;
            bytes_left_q   <= bytes_left_d;
            ones_q         <= ones_d;
            stuff_to_eop_q <= stuff_to_eop_d;
            level_q        <= level_d;
            tx_error_q     <= tx_error_d;
            tx_done_q      <= tx_done_d;
        end
    end

    // Current bit, its NRZI level and the resulting pin pair.
    always_comb begin
        cur_bit = 1'b1;
        dp_out  = 1'b1;
        dm_out  = 1'b0;
        case (state_q)
            ST_SYNC:  cur_bit = (bit_idx_q == 3'd7);
            ST_DATA:  cur_bit = serial_in;
            ST_STUFF: cur_bit = 1'b0;
            default:  cur_bit = 1'b1;
        endcase
        nrzi_level = cur_bit ? level_q : ~level_q;
        case (state_q)
            ST_SYNC, ST_DATA, ST_STUFF: begin
                dp_out = nrzi_level;
                dm_out = ~nrzi_level;
            end
            ST_EOP_SE0: begin
                dp_out = 1'b0;
                dm_out = 1'b0;
            end
            default: begin
                dp_out = 1'b1;
                dm_out = 1'b0;
            end
        endcase
    end

    // Next-state, bit-period bookkeeping and shift register strobes.
    always_comb begin
        state_d        = state_q;
        clk_cnt_d      = clk_cnt_q;
        bit_idx_d      = bit_idx_q;
        bytes_left_d   = bytes_left_q;
        ones_d         = ones_q;
        stuff_to_eop_d = stuff_to_eop_q;
        level_d        = level_q;
        tx_error_d     = 1'b0;
        tx_done_d      = 1'b0;
        load_data      = 1'b0;
        shift_en       = 1'b0;
        data_to_eop    = 1'b0;

        if (state_q != ST_IDLE) begin
            clk_cnt_d = bit_tick ? '0 : (clk_cnt_q + CLK_W'(1));
        end
        if (bit_tick && (state_q == ST_SYNC || state_q == ST_DATA || state_q == ST_STUFF)) begin
            level_d = nrzi_level;
        end

        case (state_q)
            ST_IDLE: begin
                level_d   = 1'b1;
                clk_cnt_d = '0;
                if (tx_start) begin
                    if (tx_byte_count != '0) begin
                        state_d      = ST_SYNC;
                        bytes_left_d = tx_byte_count;
                        bit_idx_d    = '0;
                        ones_d       = '0;
                    end else begin
                        tx_error_d = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        ones_d    = 3'd1;
                        bit_idx_d = '0;
                        if (!buffer_empty) begin
                            load_data = 1'b1;
                            state_d   = ST_DATA;
                        end else begin
                            tx_error_d = 1'b1;
                            state_d    = ST_EOP_SE0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    ones_d = ones_next;
                    if (bit_idx_q != 3'd7) begin
                        shift_en  = 1'b1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        bytes_left_d = bytes_left_q - CNT_W'(1);
                        if (bytes_left_q > CNT_W'(1)) begin
                            if (!buffer_empty) begin
                                load_data = 1'b1;
                                bit_idx_d = '0;
                            end else begin
                                tx_error_d  = 1'b1;
                                data_to_eop = 1'b1;
                            end
                        end else begin
                            data_to_eop = 1'b1;
                        end
                    end
                    if (data_to_eop) begin
                        bit_idx_d = '0;
                    end
                    // A sixth consecutive one forces a stuffed zero first.
                    if (ones_next == 3'd6) begin
                        state_d        = ST_STUFF;
                        stuff_to_eop_d = data_to_eop;
                    end else if (data_to_eop) begin
                        state_d = ST_EOP_SE0;
                    end
                end
            end
            ST_STUFF: begin
                if (bit_tick) begin
                    ones_d  = '0;
                    state_d = stuff_to_eop_q ? ST_EOP_SE0 : ST_DATA;
                end
            end
            ST_EOP_SE0: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd1) begin
                        bit_idx_d = '0;
                        state_d   = ST_EOP_J;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_tick) begin
                    state_d   = ST_IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/tx_shift_sequencer.md
Name: tx_shift_sequencer

Overview:
- Sequences the TX parallel-in/serial-out byte shift register to transmit one USB full-speed packet.
- Sends SYNC, then pops and shifts out N bytes from the TX buffer, with bit stuffing and NRZI encoding.
- Finishes with EOP and drives the differential line outputs.
- Sits between the TX packet buffer and the USB transceiver pins; the shift register feeds serial data back through `serial_in`.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per USB bit period (≥2).
- CNT_W, 7, width of the byte-count input (max 127 bytes).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tx_start  in  1  single-cycle request; ignored while tx_busy=1
- tx_byte_count  in  CNT_W  bytes to send; sampled with tx_start
- buffer_empty  in  1  TX buffer has no byte available
- serial_in  in  1  shift register MSB (current data bit)
- load_data  out  1  load shift register from buffer (1 cycle)
- byte_pop  out  1  pop buffer; always coincident with load_data
- shift_en  out  1  advance shift register by one bit (1 cycle)
- dp_out  out  1  D+ line
- dm_out  out  1  D- line
- tx_busy  out  1  high from the cycle after an accepted tx_start until tx_done
- tx_done  out  1  1-cycle pulse on return to IDLE
- tx_error  out  1  1-cycle pulse on zero count or buffer underflow

Behaviour:
- Reset (async, any state):
  - state=IDLE, dp_out=1, dm_out=0 (J).
  - All other outputs 0; counters cleared.
- Line encoding:
  - J={1,0}, K={0,1}, SE0={0,0}.
  - NRZI: bit 0 toggles J<->K; bit 1 holds the previous level.
  - The line updates only on the first cycle of each bit period and holds for CLKS_PER_BIT cycles.
- bit_tick: asserted on the last cycle of each bit period (clk_cnt == CLKS_PER_BIT-1). clk_cnt wraps to 0.
- IDLE: drive J; load_data, shift_en and byte_pop are 0.
  - tx_start with count ≠ 0: latch bytes_left=count, go to SYNC next cycle, tx_busy=1.
  - tx_start with count = 0: tx_error pulse next cycle; stay IDLE; no tx_done.
- SYNC: 8 bit periods of the internal pattern 0,0,0,0,0,0,0,1 (LSB-first 0x80). Line sequence is K J K J K J K K.
  - ones_cnt=1 on exit.
  - On bit_tick of the 8th period:
    - buffer_empty=0: assert load_data+byte_pop, go to DATA, bit_idx=0.
    - buffer_empty=1: go to EOP_SE0 with tx_error pulse.
- DATA: each bit period drives the NRZI of serial_in sampled on the period's first cycle.
  - ones_cnt increments on 1 and clears on 0.
  - On bit_tick:
    - bit_idx<7: shift_en=1, bit_idx++.
    - bit_idx=7: bytes_left--.
    - bit_idx=7 and bytes_left was >1: if buffer_empty=0, assert load_data+byte_pop and set bit_idx=0; otherwise go to EOP_SE0 with a tx_error pulse.
    - bit_idx=7 and last byte: next is EOP_SE0.
  - Stuffing takes priority: if ones_cnt reaches 6 at this bit_tick, the next period is STUFF. The shift/load above still occurs; the post-STUFF destination is remembered.
- STUFF: one bit period transmitting a 0 (line toggles). No shift_en, no load. ones_cnt=0. Then go to the remembered destination (DATA or EOP_SE0).
  - Stuffing after the final byte's bit 7 is still inserted before EOP.
- EOP_SE0: 2 bit periods of SE0. Then EOP_J: 1 bit period of J. Then IDLE.
  - tx_done pulses on the first IDLE cycle; tx_busy clears the same cycle.
- Shift register contract:
  - load_data takes priority over shift_en in the shift register.
  - The sequencer never asserts both in one cycle.
  - shift_en and load_data are only ever asserted on bit_tick.
- Simultaneous events:
  - tx_start while busy: ignored.
  - buffer_empty changes mid-byte: no effect until the next load point.
- Reset mid-packet: line returns to J immediately; no EOP, no tx_done.

Test Plan:
- Single byte: CLKS_PER_BIT=8, count=1, byte 0x00 → line K J K J K J K K, then J K J K J K J K (8 cycles each), SE0 16 cycles, J 8 cycles; exactly one load_data/byte_pop and 7 shift_en; tx_done 153 cycles after tx_start.
- Stuffing: count=1, byte 0xFF → after SYNC, 5 held-K periods, one STUFF toggle to J, 3 more held-J periods, then EOP; 9 data-phase periods total; 7 shift_en.
- Multi-byte: count=3, bytes 0xA5, 0x3C, 0x00 → load_data pulses exactly at bit boundaries 8, 16, 24 (periods since SYNC start); no gap cycles; 21 shift_en; tx_done once.
- Underflow: count=2, buffer_empty rises after the first pop → after byte 1 bit 7: tx_error pulse, SE0 2 periods, J 1 period, tx_done; byte_pop pulsed once.
- Zero count / busy: tx_start with count=0 → tx_error one cycle, line stays J. tx_start during an active packet → ignored; packet length unchanged.
- Reset mid-DATA: assert rst during byte 2 → dp_out=1, dm_out=0, tx_busy=0 asynchronously; no tx_done; the next tx_start transmits normally.
